coin_acceptor: RTL and testbench

Front-end conditioner that sits directly upstream of the `vend` controller. It turns raw, asynchronous coin-chute sensors and newspaper-select buttons into clean synchronous signals. Each accepted coin becomes a single-cycle `in` code (1 = 5-unit, 2 = 10-unit), and the buttons become mutually exclusive `star_pb` / `straits_pb` levels. Coins arriving faster than `vend` should see them are queued and paced; coins that cannot be queued are returned.

---
 rtl/vend_pkg.sv | 27 ++
 rtl/input_debounce.sv | 54 +++++
 rtl/coin_acceptor.sv | 186 ++++++++++++++++++
 tb/tb_coin_acceptor.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// ----------------------------------------------------------------------------
// vend_pkg
// Types shared by the coin acceptor front-end and the vend controller: the
// 2-bit coin codes presented on `in`, the coin emit FSM states and the
// newspaper-select button arbiter states.
// ----------------------------------------------------------------------------
package vend_pkg;

  typedef enum logic [1:0] {
    COIN_NONE = 2'd0,
    COIN_5    = 2'd1,
    COIN_10   = 2'd2
  } coin_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    GAP  = 2'd2
  } emit_state_t;

  typedef enum logic [1:0] {
    BTN_NONE    = 2'd0,
    BTN_STAR    = 2'd1,
    BTN_STRAITS = 2'd2
  } btn_state_t;

endpackage

// File: rtl/input_debounce.sv
// ----------------------------------------------------------------------------
// input_debounce
// Two-flop synchronizer followed by a counting debouncer. The stable level
// flips only after DEBOUNCE_CYCLES consecutive synchronized samples that
// differ from it; any sample equal to the stable level restarts the count.
//
// Ports:
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   i_raw    asynchronous raw input
//   o_level  debounced level, synchronous to clk
// ----------------------------------------------------------------------------
module input_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic [CW-1:0] r_cnt;

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values; with = the synchronizer would collapse into one flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        // This sample is the DEBOUNCE_CYCLES-th differing one.
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_level = r_stable;

endmodule

// File: rtl/coin_acceptor.sv
// ----------------------------------------------------------------------------
// coin_acceptor
// Front-end conditioner for the vend controller. Debounces coin sensors and
// select buttons, turns coin rising edges into queued 2-bit codes, paces them
// onto `in` with a forced idle gap, and arbitrates the two select buttons.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   coin5_raw    5-unit chute sensor (async)
//   coin10_raw   10-unit chute sensor (async)
//   star_raw     Star select button (async)
//   straits_raw  Straits select button (async)
//   in           coin code to vend (0 none, 1 five, 2 ten), one cycle per coin
//   star_pb      arbitrated Star select level
//   straits_pb   arbitrated Straits select level
//   coin_return  one-cycle pulse, coin rejected
//   fifo_full    coin queue holds FIFO_DEPTH events
// ----------------------------------------------------------------------------
module coin_acceptor
  import vend_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int COIN_GAP        = 2,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin5_raw,
  input  logic       coin10_raw,
  input  logic       star_raw,
  input  logic       straits_raw,
  output logic [1:0] in,
  output logic       star_pb,
  output logic       straits_pb,
  output logic       coin_return,
  output logic       fifo_full
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int GW = $clog2(COIN_GAP + 1);

  logic w_coin5, w_coin10, w_star, w_straits;

  input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_coin5 (
    .clk(clk), .rst_n(rst), .i_raw(coin5_raw), .o_level(w_coin5));
  input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_coin10 (
    .clk(clk), .rst_n(rst), .i_raw(coin10_raw), .o_level(w_coin10));
  input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_star (
    .clk(clk), .rst_n(rst), .i_raw(star_raw), .o_level(w_star));
  input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_straits (
    .clk(clk), .rst_n(rst), .i_raw(straits_raw), .o_level(w_straits));

  // Coin edge detection and queue control
  logic          r_coin5_d, r_coin10_d;
  logic          w_rise5, w_rise10, w_both, w_push_req, w_push, w_pop, w_drop;
  coin_t         w_push_code;
  coin_t         r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr, w_wr_next, w_rd_next;
  logic          w_empty, w_full, w_full_next;

  assign w_rise5    = w_coin5 & ~r_coin5_d;
  assign w_rise10   = w_coin10 & ~r_coin10_d;
  // Two coins whose edges coincide cannot be told apart: reject both.
  assign w_both     = w_rise5 & w_rise10;
  assign w_push_req = w_rise5 ^ w_rise10;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_push_code = COIN_10;
    if (w_rise5) w_push_code = COIN_5;
  end

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  // A pop in the same cycle frees the slot the push needs.
  assign w_push  = w_push_req && (!w_full || w_pop);
  assign w_drop  = w_push_req && w_full && !w_pop;

  assign w_wr_next   = r_wr_ptr + PW'(w_push);
  assign w_rd_next   = r_rd_ptr + PW'(w_pop);
  assign w_full_next = (w_wr_next[AW] != w_rd_next[AW]) &&
                       (w_wr_next[AW-1:0] == w_rd_next[AW-1:0]);

  // NOTE: the queue storage has no reset; the pointers alone define which
  // entries are valid, so clearing them empties the queue.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= w_push_code;
  end

  // Emit FSM: IDLE -> EMIT (pop) -> GAP x COIN_GAP -> EMIT or IDLE
  emit_state_t   r_emit_state, w_emit_next;
  logic [GW-1:0] r_gap_cnt, w_gap_cnt_next;

  always_comb begin
    w_emit_next    = r_emit_state;
    w_gap_cnt_next = r_gap_cnt;
    w_pop          = 1'b0;
    unique case (r_emit_state)
      IDLE: begin
        if (!w_empty) begin
          w_emit_next = EMIT;
          w_pop       = 1'b1;
        end
      end
      EMIT: begin
        w_emit_next    = GAP;
        w_gap_cnt_next = '0;
      end
      GAP: begin
        if (r_gap_cnt == GW'(COIN_GAP - 1)) begin
          if (!w_empty) begin
            w_emit_next = EMIT;
            w_pop       = 1'b1;
          end else begin
            w_emit_next = IDLE;
          end
        end else begin
          w_gap_cnt_next = r_gap_cnt + GW'(1);
        end
      end
      default: w_emit_next = IDLE;
    endcase
  end

  // Button arbiter: first debounced press wins, Star on a tie; held until
  // that button is released.
  btn_state_t r_btn, w_btn_next;

  always_comb begin
    w_btn_next = r_btn;
    unique case (r_btn)
      BTN_NONE: begin
        if (w_star)         w_btn_next = BTN_STAR;
        else if (w_straits) w_btn_next = BTN_STRAITS;
      end
      BTN_STAR:    if (!w_star)    w_btn_next = BTN_NONE;
      BTN_STRAITS: if (!w_straits) w_btn_next = BTN_NONE;
      default:     w_btn_next = BTN_NONE;
    endcase
  end

  coin_t r_in;
  logic  r_star_pb, r_straits_pb, r_coin_return, r_fifo_full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_coin5_d     <= 1'b0;
      r_coin10_d    <= 1'b0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_emit_state  <= IDLE;
      r_gap_cnt     <= '0;
      r_btn         <= BTN_NONE;
      r_in          <= COIN_NONE;
      r_star_pb     <= 1'b0;
      r_straits_pb  <= 1'b0;
      r_coin_return <= 1'b0;
      r_fifo_full   <= 1'b0;
    end else begin
      r_coin5_d     <= w_coin5;
      r_coin10_d    <= w_coin10;
      r_wr_ptr      <= w_wr_next;
      r_rd_ptr      <= w_rd_next;
      r_emit_state  <= w_emit_next;
      r_gap_cnt     <= w_gap_cnt_next;
      r_btn         <= w_btn_next;
      if (w_pop) r_in <= r_mem[r_rd_ptr[AW-1:0]];
      else       r_in <= COIN_NONE;
      r_star_pb     <= (w_btn_next == BTN_STAR);
      r_straits_pb  <= (w_btn_next == BTN_STRAITS);
      r_coin_return <= w_both || w_drop;
      r_fifo_full   <= w_full_next;
    end
  end

  assign in          = r_in;
  assign star_pb     = r_star_pb;
  assign straits_pb  = r_straits_pb;
  assign coin_return = r_coin_return;
  assign fifo_full   = r_fifo_full;

endmodule

// File: tb/tb_coin_acceptor.sv
// ----------------------------------------------------------------------------
// tb_coin_acceptor
// Scoreboard bench for coin_acceptor. Instance u_a (D=4, GAP=2, DEPTH=4)
// covers latency, glitch rejection, simultaneous coins and buttons. Instance
// u_b (D=2, GAP=2, DEPTH=4) debounces fast enough that two interleaved chutes
// outrun the emitter, so its queue fills, overflows and is reset while loaded.
// Expected coin codes and coin_return pulses are queued by the stimulus and
// consumed by a monitor sampling on the falling edge.
// ----------------------------------------------------------------------------
module tb_coin_acceptor;
  import vend_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       a_c5, a_c10, a_star, a_str;
  logic [1:0] a_in;
  logic       a_star_pb, a_str_pb, a_ret, a_full;
  logic       b_c5, b_c10;
  logic [1:0] b_in;
  logic       b_star_pb, b_str_pb, b_ret, b_full;

  coin_acceptor #(.DEBOUNCE_CYCLES(4), .COIN_GAP(2), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .rst(rst), .coin5_raw(a_c5), .coin10_raw(a_c10),
    .star_raw(a_star), .straits_raw(a_str), .in(a_in), .star_pb(a_star_pb),
    .straits_pb(a_str_pb), .coin_return(a_ret), .fifo_full(a_full));

  coin_acceptor #(.DEBOUNCE_CYCLES(2), .COIN_GAP(2), .FIFO_DEPTH(4)) u_b (
    .clk(clk), .rst(rst), .coin5_raw(b_c5), .coin10_raw(b_c10),
    .star_raw(1'b0), .straits_raw(1'b0), .in(b_in), .star_pb(b_star_pb),
    .straits_pb(b_str_pb), .coin_return(b_ret), .fifo_full(b_full));

  typedef struct {
    logic [1:0] code;
    int         at_edge;   // -1: order only, no cycle check
  } exp_t;

  exp_t exp_a[$];
  exp_t exp_b[$];
  int   ret_a = 0;
  int   ret_b = 0;
  int   b_last = -100;
  int   n_tests = 0;
  int   n_fail = 0;
  int   edge_n = 0;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Advance to the falling edge that follows rising edge number `target`.
  task automatic to_edge_neg(input int target);
    while (edge_n < target) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
  endtask

  // Monitor: consumes expectations whenever the DUTs present an event.
  exp_t e;
  always @(negedge clk) begin
    if (rst) begin
      if (a_in != 2'd0) begin
        if (exp_a.size() == 0) check("a_unexpected_in", a_in, 0);
        else begin
          e = exp_a.pop_front();
          check("a_in_code", a_in, e.code);
          if (e.at_edge >= 0) check("a_in_edge", edge_n, e.at_edge);
        end
      end
      if (b_in != 2'd0) begin
        if (exp_b.size() == 0) check("b_unexpected_in", b_in, 0);
        else begin
          e = exp_b.pop_front();
          check("b_in_code", b_in, e.code);
        end
        if (edge_n - b_last < 10) check("b_spacing", edge_n - b_last, 3);
        b_last = edge_n;
      end
      if (a_ret) begin
        check("a_return_expected", ret_a > 0, 1);
        if (ret_a > 0) ret_a--;
      end
      if (b_ret) begin
        check("b_return_expected", ret_b > 0, 1);
        if (ret_b > 0) ret_b--;
      end
    end
    check("a_pb_exclusive", a_star_pb & a_str_pb, 0);
  end

  int k;
  int k2;

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    a_c5 = 0; a_c10 = 0; a_star = 0; a_str = 0; b_c5 = 0; b_c10 = 0;
    step(2);
    check("rst_a_in", a_in, 0);
    check("rst_a_pb", {a_star_pb, a_str_pb}, 0);
    check("rst_a_ret_full", {a_ret, a_full}, 0);
    check("rst_b_outputs", {b_in, b_ret, b_full}, 0);
    rst = 1'b1;
    step(5);

    // 1: clean 5-unit coin, in = 1 after edge 7 (edge 0 samples the raw high)
    k = edge_n;
    exp_a.push_back('{2'd1, k + 8});
    a_c5 = 1; step(10);
    a_c5 = 0; step(20);
    check("t1_drained", exp_a.size(), 0);

    // 2: bouncing 10-unit sensor, then steady: exactly one code 2
    for (int i = 0; i < 20; i++) begin
      a_c10 = ((i % 4) < 2);
      step(1);
    end
    exp_a.push_back('{2'd2, -1});
    a_c10 = 1; step(15);
    a_c10 = 0; step(15);
    check("t2_drained", exp_a.size(), 0);

    // 4: both chutes rise together: one coin_return, no code
    ret_a = 1;
    a_c5 = 1; a_c10 = 1; step(10);
    a_c5 = 0; a_c10 = 0; step(15);
    check("t4_return_seen", ret_a, 0);

    // 5: Star held, Straits pressed, Star released
    k = edge_n;
    a_star = 1;
    to_edge_neg(k + 6);
    check("t5_star_early", a_star_pb, 0);
    to_edge_neg(k + 7);
    check("t5_star_rise", {a_star_pb, a_str_pb}, 2'b10);
    a_str = 1;
    to_edge_neg(k + 22);
    check("t5_straits_ignored", {a_star_pb, a_str_pb}, 2'b10);
    k2 = edge_n;
    a_star = 0;
    to_edge_neg(k2 + 6);
    check("t5_star_held", {a_star_pb, a_str_pb}, 2'b10);
    to_edge_neg(k2 + 7);
    check("t5_both_low", {a_star_pb, a_str_pb}, 2'b00);
    to_edge_neg(k2 + 8);
    check("t5_straits_taken", {a_star_pb, a_str_pb}, 2'b01);
    k2 = edge_n;
    a_str = 0;
    to_edge_neg(k2 + 7);
    check("t5_straits_release", {a_star_pb, a_str_pb}, 2'b00);

    // 5b: simultaneous press, Star wins
    k = edge_n;
    a_star = 1; a_str = 1;
    to_edge_neg(k + 7);
    check("t5_tie_star_wins", {a_star_pb, a_str_pb}, 2'b10);
    a_star = 0; a_str = 0;
    step(12);
    check("t5_tie_release", {a_star_pb, a_str_pb}, 2'b00);

    // 3: interleaved chutes on u_b fill the queue; 12 coins, the 12th dropped
    for (int i = 0; i < 11; i++)
      exp_b.push_back('{(i % 2 == 0) ? 2'd1 : 2'd2, -1});
    ret_b = 1;
    k = edge_n;
    for (int c = 0; c < 25; c++) begin
      b_c5  = (c < 24) && ((c % 4) < 2);
      b_c10 = (c >= 1) && (c < 25) && (((c - 1) % 4) < 2);
      if (c == 21) begin
        @(negedge clk);
        check("t3_not_full_at_3", b_full, 0);
      end
      if (c == 22) begin
        @(negedge clk);
        check("t3_full_at_4", b_full, 1);
      end
      step(1);
    end
    b_c5 = 0; b_c10 = 0;
    step(60);
    check("t3_drained", exp_b.size(), 0);
    check("t3_one_return", ret_b, 0);
    check("t3_full_cleared", b_full, 0);

    // 6: reset with three coins queued in u_b and Star selected on u_a
    a_star = 1;
    k = edge_n;
    to_edge_neg(k + 8);
    check("t6_pre_star", a_star_pb, 1);
    exp_b.push_back('{2'd1, -1});
    exp_b.push_back('{2'd2, -1});
    exp_b.push_back('{2'd1, -1});
    k = edge_n;
    for (int c = 0; c < 14; c++) begin
      b_c5  = (c < 12) && ((c % 4) < 2);
      b_c10 = (c >= 1) && (c < 13) && (((c - 1) % 4) < 2);
      step(1);
    end
    check("t6_pre_reset_emitted", exp_b.size(), 0);
    rst = 1'b0;
    #1;
    check("t6_rst_a_pb", {a_star_pb, a_str_pb}, 0);
    check("t6_rst_a_in_ret", {a_in, a_ret, a_full}, 0);
    check("t6_rst_b", {b_in, b_ret, b_full}, 0);
    a_star = 0;
    step(3);
    rst = 1'b1;
    step(30);
    check("t6_no_return", ret_b, 0);
    check("t6_b_idle", {b_in, b_ret, b_full}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
